// File: rtl/mult8_rr_sched_if.sv
// mult8_rr_sched_if: two operand requesters plus one result consumer, with status
interface mult8_rr_sched_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [7:0]  req0_a;
    logic [7:0]  req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [7:0]  req1_a;
    logic [7:0]  req1_b;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_p;
    logic        res_id;
    logic        busy;

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
        input  req0_ready, req1_ready, res_valid, res_p, res_id, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
        output req0_ready, req1_ready, res_valid, res_p, res_id, busy
    );
endinterface

// File: rtl/mult8_rr_sched.sv
// mult8_rr_sched: round-robin 8x8 multiplier built from four passes through a 4x4 core
module main (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] o
);
    assign o = {4'd0, x} * {4'd0, y};
endmodule

module mult8_rr_sched #(
    parameter bit RR_INIT = 1'b0
) (
    input logic clk,
    input logic rst_n,
    mult8_rr_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_d;
    logic [1:0]  step, step_d;
    logic [15:0] acc, acc_d, part;
    logic [7:0]  a, a_d, b, b_d;
    logic        id, id_d, last_grant, last_d;
    logic        gnt_any, gnt_id;
    logic [3:0]  x, y;
    logic [7:0]  o;

    main core (.x(x), .y(y), .o(o));

    // Grant a lone requester; a tie goes to whoever was not served last
    always_comb begin
        gnt_any = bus.req0_valid | bus.req1_valid;
        gnt_id = (bus.req0_valid & bus.req1_valid) ? ~last_grant : bus.req1_valid;
        bus.req0_ready = (state == IDLE) & gnt_any & ~gnt_id;
        bus.req1_ready = (state == IDLE) & gnt_any & gnt_id;
        bus.res_valid = state == DONE;
        bus.res_p = bus.res_valid ? acc : 16'd0;
        bus.res_id = bus.res_valid & id;
        bus.busy = state != IDLE;
    end

    // Pick the nibble pair for this step and its weight; the core sees zeros outside CALC
    always_comb begin
        x = (state != CALC) ? 4'd0 : step[0] ? a[7:4] : a[3:0];
        y = (state != CALC) ? 4'd0 : step[1] ? b[7:4] : b[3:0];
        part = (step == 2'd3) ? {o, 8'd0} : (step == 2'd0) ? {8'd0, o} : {4'd0, o, 4'd0};
    end

    // Next state: accept in IDLE, accumulate four partials in CALC, hold the result in DONE
    always_comb begin
        state_d = state;
        step_d = step;
        acc_d = acc;
        a_d = a;
        b_d = b;
        id_d = id;
        last_d = last_grant;
        if (state == IDLE && gnt_any) begin
            state_d = CALC;
            step_d = 2'd0;
            acc_d = 16'd0;
            a_d = gnt_id ? bus.req1_a : bus.req0_a;
            b_d = gnt_id ? bus.req1_b : bus.req0_b;
            id_d = gnt_id;
            last_d = gnt_id;
        end else if (state == CALC) begin
            acc_d = acc + part;
            step_d = step + 2'd1;
            state_d = (step == 2'd3) ? DONE : CALC;
        end else if (state == DONE && bus.res_ready) begin
            state_d = IDLE;
        end
    end

    // State and datapath registers; reset drops any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            step <= 2'd0;
            acc <= 16'd0;
            a <= 8'd0;
            b <= 8'd0;
            id <= 1'b0;
            last_grant <= ~RR_INIT;
        end else begin
            state <= state_d;
            step <= step_d;
            acc <= acc_d;
            a <= a_d;
            b <= b_d;
            id <= id_d;
            last_grant <= last_d;
        end
    end
endmodule
